spdif_feed_ctrl: RTL and testbench

SPDIF_FEED_CTRL -- requirements
Module: spdif_feed_ctrl

---
 rtl/spdif_feed_ctrl_if.sv | 25 ++
 rtl/spdif_feed_ctrl.sv | 147 ++++++++++++++
 tb/tb_spdif_feed_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/spdif_feed_ctrl_if.sv
// Source-side sample handshake and TX-side enable/read/sample bus for spdif_feed_ctrl.
// Signal suffixes are taken from the controller's point of view (slave modport).
interface spdif_feed_ctrl_if #(
  parameter int SRCS  = 2,
  parameter int PCM_W = 24
);
  logic [PCM_W-1:0] src_L_i [SRCS];
  logic [PCM_W-1:0] src_R_i [SRCS];
  logic [SRCS-1:0]  src_vld_i;
  logic [SRCS-1:0]  src_rdy_o;
  logic             en_o;
  logic             pcm_rd_i;
  logic [PCM_W-1:0] pcm_L_o;
  logic [PCM_W-1:0] pcm_R_o;

  modport master (
    output src_L_i, src_R_i, src_vld_i, pcm_rd_i,
    input  src_rdy_o, en_o, pcm_L_o, pcm_R_o
  );

  modport slave (
    input  src_L_i, src_R_i, src_vld_i, pcm_rd_i,
    output src_rdy_o, en_o, pcm_L_o, pcm_R_o
  );
endinterface

// File: rtl/spdif_feed_ctrl.sv
// Feeds stereo PCM from one of SRCS sources to an S/PDIF TX: Fs*128 enable from a phase
// accumulator, muted zero frames on start/switch, underrun counting. Source pulled only on pcm_rd_i.
module spdif_feed_ctrl #(
  parameter int SRCS     = 2,
  parameter int PCM_W    = 24,
  parameter int ACC_W    = 24,
  parameter int INC_48K  = 2097152,
  parameter int INC_44K1 = 1926758,
  parameter int MUTE_N   = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    run_i,
  input  logic                    fs_44k1_i,
  input  logic [$clog2(SRCS)-1:0] sel_i,
  output logic [$clog2(SRCS)-1:0] act_o,
  output logic                    muted_o,
  output logic [7:0]              err_cnt_o,
  input  logic                    err_clr_i,
  spdif_feed_ctrl_if.slave        bus
);
  localparam int SW = $clog2(SRCS);
  localparam logic [ACC_W-1:0] INC48 = ACC_W'(INC_48K);
  localparam logic [ACC_W-1:0] INC44 = ACC_W'(INC_44K1);
  localparam logic [7:0]       MUTE_LOAD = 8'(MUTE_N - 1);

  typedef enum logic [1:0] {IDLE, MUTE, RUN} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             en_q, en_d;
  logic [PCM_W-1:0] pcm_L_q, pcm_L_d, pcm_R_q, pcm_R_d;
  logic [SW-1:0]    act_q, act_d;
  logic [7:0]       mcnt_q, mcnt_d;
  logic [7:0]       err_q, err_d;
  logic [SRCS-1:0]  rdy;
  logic             err_inc;
  logic             act_ok;
  logic [ACC_W:0]   sum;

  // act_q can exceed the source count when SRCS is not a power of two
  assign act_ok = ({1'b0, act_q} < (SW+1)'(SRCS));
  assign sum    = {1'b0, acc_q} + {1'b0, (fs_44k1_i ? INC44 : INC48)};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    en_d    = 1'b0;
    pcm_L_d = pcm_L_q;
    pcm_R_d = pcm_R_q;
    act_d   = act_q;
    mcnt_d  = mcnt_q;
    rdy     = '0;
    err_inc = 1'b0;
    if (!run_i) begin
      state_d = IDLE;
      acc_d   = '0;
      pcm_L_d = '0;
      pcm_R_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          acc_d   = '0;
          pcm_L_d = '0;
          pcm_R_d = '0;
          act_d   = sel_i;
          mcnt_d  = MUTE_LOAD;
          state_d = MUTE;
        end
        MUTE: begin
          acc_d = sum[ACC_W-1:0];
          en_d  = sum[ACC_W];
          if (bus.pcm_rd_i) begin
            pcm_L_d = '0;
            pcm_R_d = '0;
            if (!act_ok && sel_i != act_q) begin
              act_d  = sel_i;
              mcnt_d = MUTE_LOAD;
            end else if (mcnt_q == 8'd0 && act_ok) begin
              state_d = RUN;
            end else if (mcnt_q != 8'd0) begin
              mcnt_d = mcnt_q - 8'd1;
            end
          end
        end
        RUN: begin
          acc_d = sum[ACC_W-1:0];
          en_d  = sum[ACC_W];
          if (bus.pcm_rd_i) begin
            if (sel_i == act_q) begin
              rdy[act_q] = 1'b1;
              if (bus.src_vld_i[act_q]) begin
                pcm_L_d = bus.src_L_i[act_q];
                pcm_R_d = bus.src_R_i[act_q];
              end else begin
                pcm_L_d = '0;
                pcm_R_d = '0;
                err_inc = 1'b1;
              end
            end else begin
              pcm_L_d = '0;
              pcm_R_d = '0;
              act_d   = sel_i;
              mcnt_d  = MUTE_LOAD;
              state_d = MUTE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // clear wins over a same-cycle underrun
    if (err_clr_i)                    err_d = 8'd0;
    else if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
    else                              err_d = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      en_q    <= 1'b0;
      pcm_L_q <= '0;
      pcm_R_q <= '0;
      act_q   <= '0;
      mcnt_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      en_q    <= en_d;
      pcm_L_q <= pcm_L_d;
      pcm_R_q <= pcm_R_d;
      act_q   <= act_d;
      mcnt_q  <= mcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.src_rdy_o = (rst_i) ? '0 : rdy;
  assign bus.en_o      = en_q;
  assign bus.pcm_L_o   = pcm_L_q;
  assign bus.pcm_R_o   = pcm_R_q;
  assign act_o         = act_q;
  assign muted_o       = (state_q != RUN);
  assign err_cnt_o     = err_q;
endmodule

// File: tb/tb_spdif_feed_ctrl.sv
// Directed bench for spdif_feed_ctrl at default parameters: enable cadence, mute/run,
// source switch, underrun/saturation, reset and stop behaviour.
module tb_spdif_feed_ctrl;
  logic       clk;
  logic       rst;
  logic       run;
  logic       fs44;
  logic [0:0] sel;
  logic [0:0] act;
  logic       muted;
  logic [7:0] err_cnt;
  logic       err_clr;
  logic [1:0] rdy_seen;
  int         total = 0;
  int         bad   = 0;

  spdif_feed_ctrl_if #(.SRCS(2), .PCM_W(24)) bus ();

  spdif_feed_ctrl dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .run_i     (run),
    .fs_44k1_i (fs44),
    .sel_i     (sel),
    .act_o     (act),
    .muted_o   (muted),
    .err_cnt_o (err_cnt),
    .err_clr_i (err_clr),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one-clock read strobe; src_rdy_o is captured mid-cycle while the strobe is high
  task automatic rd();
    bus.pcm_rd_i = 1'b1;
    @(negedge clk);
    rdy_seen = bus.src_rdy_o;
    step();
    bus.pcm_rd_i = 1'b0;
  endtask

  task automatic set_src(input logic [23:0] k);
    bus.src_L_i[0] = 24'h100000 + k;
    bus.src_R_i[0] = 24'h200000 + k;
    bus.src_L_i[1] = 24'h300000 + k;
    bus.src_R_i[1] = 24'h400000 + k;
  endtask

  initial begin
    int n_en, last, sp_bad, nz, rdy_bad;
    rst = 1'b1; run = 1'b0; fs44 = 1'b0; sel = 1'b0; err_clr = 1'b0;
    bus.pcm_rd_i = 1'b0; bus.src_vld_i = 2'b11;
    set_src(24'd0);
    repeat (3) step();

    chk("rst_pcmL", 32'(bus.pcm_L_o), 32'h0);
    chk("rst_act", 32'(act), 32'h0);
    chk("rst_err", 32'(err_cnt), 32'h0);
    chk("rst_en", 32'(bus.en_o), 32'h0);
    chk("rst_muted", 32'(muted), 32'h1);
    chk("rst_rdy", 32'(bus.src_rdy_o), 32'h0);

    // start: IDLE -> MUTE, then 48k cadence
    rst = 1'b0; run = 1'b1;
    step();
    chk("start_muted", 32'(muted), 32'h1);
    n_en = 0; last = -1; sp_bad = 0;
    for (int i = 0; i < 160; i++) begin
      step();
      if (bus.en_o) begin
        n_en++;
        if (last >= 0 && (i - last) != 8) sp_bad++;
        last = i;
      end
    end
    chk("en48_count160", 32'(n_en), 32'd20);
    chk("en48_spacing_bad", 32'(sp_bad), 32'd0);

    // 44.1k: 10000 clocks -> about 10000*1926758/2^24 = 1148.4
    fs44 = 1'b1;
    n_en = 0; last = -1; sp_bad = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (bus.en_o) begin
        n_en++;
        if (last >= 0 && (i - last) != 8 && (i - last) != 9) sp_bad++;
        last = i;
      end
    end
    chk("en44_count_in_range", 32'(n_en >= 1147 && n_en <= 1149), 32'd1);
    chk("en44_spacing_bad", 32'(sp_bad), 32'd0);
    fs44 = 1'b0;

    // 64 zero frames, the 65th read delivers source 0
    nz = 0; rdy_bad = 0;
    for (int k = 1; k <= 63; k++) begin
      set_src(24'(k));
      rd();
      if (bus.pcm_L_o !== 24'h0) nz++;
      if (rdy_seen !== 2'b00) rdy_bad++;
    end
    chk("mute63_nonzero", 32'(nz), 32'd0);
    chk("mute63_rdy", 32'(rdy_bad), 32'd0);
    chk("mute63_muted", 32'(muted), 32'h1);
    set_src(24'd64);
    rd();
    chk("mute64_pcmL", 32'(bus.pcm_L_o), 32'h0);
    chk("mute64_muted", 32'(muted), 32'h0);
    @(negedge clk);
    chk("run_idle_rdy", 32'(bus.src_rdy_o), 32'h0);
    step();
    set_src(24'd65);
    rd();
    chk("read65_rdy", 32'(rdy_seen), 32'h1);
    chk("read65_pcmL", 32'(bus.pcm_L_o), 32'h100041);
    chk("read65_pcmR", 32'(bus.pcm_R_o), 32'h200041);

    // switch to source 1: ignored until the next read
    sel = 1'b1;
    repeat (3) step();
    chk("sw_pending_act", 32'(act), 32'h0);
    chk("sw_pending_muted", 32'(muted), 32'h0);
    chk("sw_pending_pcmL", 32'(bus.pcm_L_o), 32'h100041);
    set_src(24'd66);
    rd();
    chk("sw_read_rdy", 32'(rdy_seen), 32'h0);
    chk("sw_read_act", 32'(act), 32'h1);
    chk("sw_read_muted", 32'(muted), 32'h1);
    chk("sw_read_pcmL", 32'(bus.pcm_L_o), 32'h0);
    nz = 0;
    for (int k = 0; k < 64; k++) begin
      set_src(24'(k + 100));
      rd();
      if (bus.pcm_L_o !== 24'h0 || rdy_seen !== 2'b00) nz++;
    end
    chk("sw_zero_frames", 32'(nz), 32'd0);
    set_src(24'h77);
    rd();
    chk("src1_rdy", 32'(rdy_seen), 32'h2);
    chk("src1_pcmL", 32'(bus.pcm_L_o), 32'h300077);
    chk("src1_pcmR", 32'(bus.pcm_R_o), 32'h400077);

    // underrun and saturation
    bus.src_vld_i = 2'b00;
    rd();
    chk("ur1_err", 32'(err_cnt), 32'd1);
    chk("ur1_pcmL", 32'(bus.pcm_L_o), 32'h0);
    chk("ur1_rdy", 32'(rdy_seen), 32'h2);
    nz = 0;
    for (int k = 1; k < 300; k++) begin
      rd();
      if (bus.pcm_L_o !== 24'h0 || bus.pcm_R_o !== 24'h0) nz++;
    end
    chk("ur300_nonzero", 32'(nz), 32'd0);
    chk("ur300_err_sat", 32'(err_cnt), 32'd255);
    err_clr = 1'b1;
    rd();
    err_clr = 1'b0;
    chk("clr_vs_underrun", 32'(err_cnt), 32'd0);

    // reset during MUTE with a read strobe
    bus.src_vld_i = 2'b11;
    sel = 1'b0;
    rd();
    chk("pre_rst_muted", 32'(muted), 32'h1);
    err_clr = 1'b0;
    bus.src_vld_i = 2'b00;
    rd();
    rd();
    chk("pre_rst_err_hold", 32'(err_cnt), 32'd0);
    rst = 1'b1;
    bus.pcm_rd_i = 1'b1;
    step();
    bus.pcm_rd_i = 1'b0;
    chk("mrst_act", 32'(act), 32'h0);
    chk("mrst_pcmL", 32'(bus.pcm_L_o), 32'h0);
    chk("mrst_en", 32'(bus.en_o), 32'h0);
    chk("mrst_muted", 32'(muted), 32'h1);
    rst = 1'b0;
    bus.src_vld_i = 2'b11;
    sel = 1'b1;
    step();
    chk("rerun_act", 32'(act), 32'h1);

    // back to RUN on source 1, then stop
    for (int k = 0; k < 64; k++) rd();
    set_src(24'h5);
    rd();
    chk("rerun_pcmL", 32'(bus.pcm_L_o), 32'h300005);
    run = 1'b0;
    step();
    chk("stop_muted", 32'(muted), 32'h1);
    chk("stop_pcmL", 32'(bus.pcm_L_o), 32'h0);
    n_en = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.en_o) n_en++;
    end
    chk("stop_en_silent", 32'(n_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
